// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: state encoding, reset-vector addresses and 6502 opcode length decode.
// Optional feature macro: FETCH_RESET_VECTOR_EN adds the VEC_LO/VEC_HI vector-load states.
package instr_fetch_pkg;

    localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

    typedef enum logic [2:0] {
`ifdef FETCH_RESET_VECTOR_EN
        ST_VEC_LO,
        ST_VEC_HI,
`endif
        ST_OPC,
        ST_OPR1,
        ST_OPR2,
        ST_ISSUE,
        ST_GAP
    } fetch_state_e;

    // Total instruction length in bytes (1..3) derived from the opcode's aaa/bbb/cc fields.
    function automatic logic [1:0] opcode_length(input logic [7:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [2:0] aaa;
        logic [1:0] len;
        cc  = op[1:0];
        bbb = op[4:2];
        aaa = op[7:5];
        len = 2'd1;
        if (op == 8'h20) begin
            len = 2'd3;
        end else if (op == 8'h00 || op == 8'h40 || op == 8'h60) begin
            len = 2'd1;
        end else if (cc == 2'b01) begin
            len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
        end else if (cc == 2'b11) begin
            len = 2'd1;
        end else begin
            case (bbb)
                3'b000:          len = aaa[2] ? 2'd2 : 2'd1;
                3'b001, 3'b101:  len = 2'd2;
                3'b011, 3'b111:  len = 2'd3;
                3'b100:          len = (cc == 2'b00) ? 2'd2 : 2'd1;
                default:         len = 2'd1;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/instr_fetch_mem_port.sv
// Memory read port: registers the next-cycle request/address and flags the accepted byte.
// Latency: request visible one clock after it is computed; byte_vld_o is combinational on mem_valid.
module fetch_mem_port #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_d_i,
    input  logic [ADDR_WIDTH-1:0] addr_d_i,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_valid_i,
    input  logic [REG_WIDTH-1:0]  mem_data_i,
    output logic                  byte_vld_o,
    output logic [REG_WIDTH-1:0]  byte_dat_o
);

    logic                  mem_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    // The owner keeps req/addr unchanged until byte_vld_o, so the request holds through waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_rd_q   <= req_d_i;
            mem_addr_q <= addr_d_i;
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign byte_vld_o = mem_rd_q & mem_valid_i;
    assign byte_dat_o = mem_data_i;

endmodule

// File: rtl/instr_fetch.sv
// 6502 instruction fetch sequencer: owns the PC, reads opcode plus operands, issues to the decoder.
// Optional FETCH_RESET_VECTOR_EN: load the PC from FFFC/FFFD after reset instead of RESET_PC.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_data,
    input  logic                  mem_valid,
    output logic [REG_WIDTH-1:0]  instruction_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_target
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic [REG_WIDTH-1:0]  opc_q, opc_d;
    logic [REG_WIDTH-1:0]  lo_q, lo_d;
    logic [REG_WIDTH-1:0]  hi_q, hi_d;
    logic [1:0]            len_q, len_d;
    logic                  rdy_q, rdy_d;
    logic                  req_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  byte_vld;
    logic [REG_WIDTH-1:0]  byte_dat;

    fetch_mem_port #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_port (
        .clk         (clk),
        .reset       (reset),
        .req_d_i     (req_d),
        .addr_d_i    (addr_d),
        .mem_rd_o    (mem_rd),
        .mem_addr_o  (mem_addr),
        .mem_valid_i (mem_valid),
        .mem_data_i  (mem_data),
        .byte_vld_o  (byte_vld),
        .byte_dat_o  (byte_dat)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        opc_d   = opc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        len_d   = len_q;
        case (state_q)
`ifdef FETCH_RESET_VECTOR_EN
            ST_VEC_LO: if (byte_vld) begin
                lo_d    = byte_dat;
                state_d = ST_VEC_HI;
            end
            ST_VEC_HI: if (byte_vld) begin
                pc_d    = ADDR_WIDTH'({byte_dat, lo_q});
                state_d = ST_OPC;
            end
`endif
            ST_OPC: if (byte_vld) begin
                opc_d   = byte_dat;
                ipc_d   = pc_q;
                lo_d    = '0;
                hi_d    = '0;
                len_d   = opcode_length(byte_dat[7:0]);
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = (opcode_length(byte_dat[7:0]) == 2'd1) ? ST_ISSUE : ST_OPR1;
            end
            ST_OPR1: if (byte_vld) begin
                lo_d    = byte_dat;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = (len_q == 2'd3) ? ST_OPR2 : ST_ISSUE;
            end
            ST_OPR2: if (byte_vld) begin
                hi_d    = byte_dat;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = ST_ISSUE;
            end
            ST_ISSUE: if (instruction_done) begin
                if (pc_load) pc_d = pc_target;
                state_d = ST_GAP;
            end
            ST_GAP:   state_d = ST_OPC;
            default:  state_d = state_q;
        endcase

        // Memory request and ready are registered from next state so they line up with it.
        rdy_d  = (state_d == ST_ISSUE);
        req_d  = (state_d != ST_ISSUE) && (state_d != ST_GAP);
        addr_d = pc_d;
`ifdef FETCH_RESET_VECTOR_EN
        if (state_d == ST_VEC_LO) addr_d = ADDR_WIDTH'(VEC_LO_ADDR);
        if (state_d == ST_VEC_HI) addr_d = ADDR_WIDTH'(VEC_HI_ADDR);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef FETCH_RESET_VECTOR_EN
            state_q <= ST_VEC_LO;
            pc_q    <= '0;
`else
            state_q <= ST_OPC;
            pc_q    <= RESET_PC;
`endif
            ipc_q   <= '0;
            opc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            len_q   <= 2'd1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            opc_q   <= opc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            len_q   <= len_d;
            rdy_q   <= rdy_d;
        end
    end

    assign instruction_in    = opc_q;
    assign addr_in           = ADDR_WIDTH'({hi_q, lo_q});
    assign instr_pc          = ipc_q;
    assign instruction_ready = rdy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a byte-level memory and instruction model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [7:0]  instruction_in;
    logic [15:0] addr_in;
    logic [15:0] instr_pc;
    logic        instruction_ready;
    logic        instruction_done = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;

    logic [7:0]  mem [0:65535];
    int          wait_n = 0;
    int          wcnt = 0;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] cur_pc;
    logic [15:0] start_pc;
    int          cur_len;
    logic [7:0]  exp_op;
    logic [15:0] exp_opnd;
    logic [15:0] exp_ipc;
    logic [15:0] base;

    instr_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_data          (mem_data),
        .mem_valid         (mem_valid),
        .instruction_in    (instruction_in),
        .addr_in           (addr_in),
        .instr_pc          (instr_pc),
        .instruction_ready (instruction_ready),
        .instruction_done  (instruction_done),
        .pc_load           (pc_load),
        .pc_target         (pc_target)
    );

    always #5 clk = ~clk;

    assign mem_data  = mem[mem_addr];
    assign mem_valid = (wcnt >= wait_n);

    always @(posedge clk) begin
        if (mem_rd && !mem_valid) wcnt <= wcnt + 1;
        else                      wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference instruction length, written straight from the 6502 opcode-group table.
    function automatic int ref_len(input logic [7:0] op);
        int v, cc, b, a;
        v  = int'(op);
        cc = v % 4;
        b  = (v / 4) % 8;
        a  = v / 32;
        if (v == 32'h20) return 3;
        if (v == 0 || v == 32'h40 || v == 32'h60) return 1;
        if (cc == 3) return 1;
        if (cc == 1) return (b == 3 || b == 6 || b == 7) ? 3 : 2;
        if (b == 0) return (a >= 4) ? 2 : 1;
        if (b == 1 || b == 5) return 2;
        if (b == 3 || b == 7) return 3;
        if (b == 4) return (cc == 0) ? 2 : 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b1;
        instruction_done = 1'b0;
        pc_load = 1'b0;
        repeat (2) tick();
        chk("rst_rd",   mem_rd, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_rdy",  instruction_ready, 1'b0);
        chk("rst_out",  {instruction_in, addr_in, instr_pc}, 40'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_rd", mem_rd, 1'b0);
`ifdef FETCH_RESET_VECTOR_EN
        start_pc = {mem[16'hFFFD], mem[16'hFFFC]};
`else
        start_pc = 16'h8000;
`endif
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mem_rd && mem_addr == start_pc) && n < 20);
        chk("entry", {mem_rd, mem_addr}, {1'b1, start_pc});
`ifndef FETCH_RESET_VECTOR_EN
        chk("entry_cyc", n, 1);
`endif
        cur_pc = start_pc;
    endtask

    // Called right after the edge that raised mem_rd for an opcode read.
    task automatic fetch_chk(input bit poke);
        int          n;
        int          exp_cyc;
        logic [15:0] p1, p2, prev_addr;
        bit          prev_wait;
        p1       = cur_pc + 16'd1;
        p2       = cur_pc + 16'd2;
        exp_op   = mem[cur_pc];
        cur_len  = ref_len(exp_op);
        exp_ipc  = cur_pc;
        exp_opnd = (cur_len == 3) ? {mem[p2], mem[p1]} :
                   (cur_len == 2) ? {8'h00, mem[p1]} : 16'h0000;
        exp_cyc  = cur_len * (1 + wait_n);
        prev_wait = mem_rd && !mem_valid;
        prev_addr = mem_addr;
        if (poke) begin
            instruction_done = 1'b1;
            pc_load = 1'b1;
            pc_target = 16'h1111;
        end
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            instruction_done = 1'b0;
            pc_load = 1'b0;
            if (prev_wait) chk("wait_hold", {mem_rd, mem_addr}, {1'b1, prev_addr});
            if (instruction_ready) break;
            prev_wait = mem_rd && !mem_valid;
            prev_addr = mem_addr;
        end
        chk("latency", n, exp_cyc);
        chk("opcode",  instruction_in, exp_op);
        chk("operand", addr_in, exp_opnd);
        chk("ipc",     instr_pc, exp_ipc);
    endtask

    task automatic issue(input int hold, input bit load, input logic [15:0] tgt);
        logic [15:0] nxt;
        nxt = load ? tgt : cur_pc + 16'(cur_len);
        for (int i = 0; i < hold; i++) begin
            pc_load = 1'b1;
            pc_target = 16'h5A5A;
            tick();
            chk("hold", {instruction_ready, instruction_in, addr_in, instr_pc},
                {1'b1, exp_op, exp_opnd, exp_ipc});
        end
        instruction_done = 1'b1;
        pc_load = load;
        pc_target = tgt;
        tick();
        instruction_done = 1'b0;
        pc_load = 1'b0;
        chk("gap_rdy", instruction_ready, 1'b0);
        tick();
        chk("refetch", {mem_rd, mem_addr}, {1'b1, nxt});
        cur_pc = nxt;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h90;
`ifdef FETCH_RESET_VECTOR_EN
        base = 16'h9000;
`else
        base = 16'h8000;
`endif
        // LDA #05 then INX, redirect to JSR at C000, INX at FFFF wrapping to 0000
        mem[base] = 8'hA9; mem[base + 16'd1] = 8'h05; mem[base + 16'd2] = 8'hE8;
        mem[16'hC000] = 8'h20; mem[16'hC001] = 8'h00; mem[16'hC002] = 8'h60;
        mem[16'hFFFF] = 8'hE8;
        mem[16'h0000] = 8'h60;
        mem[16'h0001] = 8'hA0; mem[16'h0002] = 8'h22;
        mem[16'h0003] = 8'h10; mem[16'h0004] = 8'hFE;
        mem[16'h0005] = 8'h0A;

        wait_n = 0;
        do_reset();
        fetch_chk(1'b0);
        chk("t1_op", {instruction_in, addr_in, instr_pc}, {8'hA9, 16'h0005, base});
        issue(0, 1'b0, 16'h0000);
        fetch_chk(1'b0);
        issue(2, 1'b1, 16'hC000);
        fetch_chk(1'b0);
        chk("jsr", {instruction_in, addr_in}, {8'h20, 16'h6000});
        issue(0, 1'b1, 16'hFFFF);
        fetch_chk(1'b0);
        chk("inx_ffff", instr_pc, 16'hFFFF);
        issue(0, 1'b0, 16'h0000);
        chk("wrap", mem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            fetch_chk(1'b0);
            issue(i % 2, 1'b0, 16'h0000);
        end

        // STA $1234 with two wait cycles per byte
        mem[base] = 8'h8D; mem[base + 16'd1] = 8'h34; mem[base + 16'd2] = 8'h12;
        wait_n = 2;
        do_reset();
        fetch_chk(1'b0);
        chk("sta_opnd", addr_in, 16'h1234);
        issue(0, 1'b0, 16'h0000);

        // done/pc_load during fetch are ignored
        wait_n = 1;
        do_reset();
        fetch_chk(1'b1);
        issue(1, 1'b0, 16'h0000);

        // reset in OPR1 aborts without issuing
        wait_n = 2;
        do_reset();
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("abort_rdy", {instruction_ready, mem_rd}, 2'b00);
        repeat (2) tick();
        chk("abort_hold", instruction_ready, 1'b0);
        do_reset();
        fetch_chk(1'b0);
        // reset while in ISSUE drops ready at once
        reset = 1'b1;
        #1;
        chk("issue_abort", instruction_ready, 1'b0);

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        wait_n = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            fetch_chk(($urandom % 5) == 0);
            wait_n = $urandom_range(0, 2);
            issue($urandom_range(0, 2), ($urandom % 4) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
